// File: rtl/semaforo_monitor.sv
// Receive-side checker for a three-lamp traffic light: decodes the phase, locks onto
// the red->amber->green sequence, flags order/length/one-hot errors and counts cycles.
module semaforo_monitor #(
    parameter int unsigned RED_TICKS   = 5,
    parameter int unsigned AMBER_TICKS = 2,
    parameter int unsigned GREEN_TICKS = 3,
    parameter int unsigned CW          = 4
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       lr,
    input  logic       la,
    input  logic       lg,
    output logic [1:0] phase,
    output logic       locked,
    output logic       err_onehot,
    output logic       err_order,
    output logic       err_len,
    output logic       err_any,
    output logic [7:0] cycles
);

    typedef enum logic [1:0] {SYNC, ALIGN, LOCK} state_t;
    typedef enum logic [1:0] {
        PH_RED   = 2'b00,
        PH_AMBER = 2'b01,
        PH_GREEN = 2'b10,
        PH_NONE  = 2'b11
    } phase_t;

    state_t        state_q;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] run_len_q, run_len_inc, ticks_cur;
    logic          locked_q, err_onehot_q, err_order_q, err_len_q, err_any_q;
    logic [7:0]    cycles_q, cycles_inc;
    logic          legal, len_ok;

    always_comb begin
        phase_d = PH_NONE;
        unique case ({lr, la, lg})
            3'b100:  phase_d = PH_RED;
            3'b010:  phase_d = PH_AMBER;
            3'b001:  phase_d = PH_GREEN;
            default: phase_d = PH_NONE;
        endcase

        // Required length of the phase held in phase_q (the run being measured).
        ticks_cur = '0;
        unique case (phase_q)
            PH_RED:   ticks_cur = CW'(RED_TICKS);
            PH_AMBER: ticks_cur = CW'(AMBER_TICKS);
            PH_GREEN: ticks_cur = CW'(GREEN_TICKS);
            default:  ticks_cur = '0;
        endcase

        legal = (phase_q == PH_RED   && phase_d == PH_AMBER) ||
                (phase_q == PH_AMBER && phase_d == PH_GREEN) ||
                (phase_q == PH_GREEN && phase_d == PH_RED);
        len_ok      = (run_len_q == ticks_cur);
        run_len_inc = (run_len_q == '1) ? run_len_q : run_len_q + CW'(1);
        cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + 8'd1;
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            state_q      <= SYNC;
            phase_q      <= PH_NONE;
            run_len_q    <= '0;
            locked_q     <= 1'b0;
            err_onehot_q <= 1'b0;
            err_order_q  <= 1'b0;
            err_len_q    <= 1'b0;
            err_any_q    <= 1'b0;
            cycles_q     <= '0;
        end else begin
            err_onehot_q <= 1'b0;
            err_order_q  <= 1'b0;
            err_len_q    <= 1'b0;
            phase_q      <= phase_d;
            if (phase_d == PH_NONE) begin
                err_onehot_q <= 1'b1;
                err_any_q    <= 1'b1;
                state_q      <= SYNC;
                locked_q     <= 1'b0;
                run_len_q    <= '0;
            end else if (phase_d != phase_q) begin
                run_len_q <= CW'(1);
                // Coming out of an invalid sample is a fresh start, not a transition.
                if (phase_q != PH_NONE) begin
                    unique case (state_q)
                        SYNC: state_q <= ALIGN;
                        ALIGN: begin
                            if (!legal) begin
                                err_order_q <= 1'b1;
                                err_any_q   <= 1'b1;
                            end else if (!len_ok) begin
                                err_len_q <= 1'b1;
                                err_any_q <= 1'b1;
                            end else begin
                                state_q  <= LOCK;
                                locked_q <= 1'b1;
                            end
                        end
                        LOCK: begin
                            if (!legal) begin
                                err_order_q <= 1'b1;
                                err_any_q   <= 1'b1;
                                state_q     <= ALIGN;
                                locked_q    <= 1'b0;
                            end else if (!len_ok) begin
                                err_len_q <= 1'b1;
                                err_any_q <= 1'b1;
                                state_q   <= ALIGN;
                                locked_q  <= 1'b0;
                            end else if (phase_q == PH_GREEN) begin
                                cycles_q <= cycles_inc;
                            end
                        end
                        default: state_q <= SYNC;
                    endcase
                end
            end else begin
                run_len_q <= run_len_inc;
                // Overlong phase: the run already met its length and is sampled again.
                if (state_q == LOCK && len_ok) begin
                    err_len_q <= 1'b1;
                    err_any_q <= 1'b1;
                    state_q   <= SYNC;
                    locked_q  <= 1'b0;
                end
            end
        end
    end

    assign phase      = phase_q;
    assign locked     = locked_q;
    assign err_onehot = err_onehot_q;
    assign err_order  = err_order_q;
    assign err_len    = err_len_q;
    assign err_any    = err_any_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Bench for semaforo_monitor: directed scenarios plus random lamp traffic, each cycle
// compared against a run-length reference model of the light-sequence rules.
module tb_semaforo_monitor;

    logic       clkin = 1'b0;
    logic       rst   = 1'b0;
    logic       lr = 1'b0, la = 1'b0, lg = 1'b0;
    logic [1:0] phase;
    logic       locked, err_onehot, err_order, err_len, err_any;
    logic [7:0] cycles;

    semaforo_monitor #(
        .RED_TICKS  (5),
        .AMBER_TICKS(2),
        .GREEN_TICKS(3),
        .CW         (4)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .lr        (lr),
        .la        (la),
        .lg        (lg),
        .phase     (phase),
        .locked    (locked),
        .err_onehot(err_onehot),
        .err_order (err_order),
        .err_len   (err_len),
        .err_any   (err_any),
        .cycles    (cycles)
    );

    always #5 clkin = ~clkin;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 = hunting, 1 = boundary known, 2 = locked.
    int   m_mode, m_ph, m_len, m_cyc;
    bit   m_any, m_eo, m_eord, m_elen;
    logic [14:0] exp_v;
    wire  [14:0] obs = {phase, locked, err_onehot, err_order, err_len, err_any, cycles};
    localparam logic [14:0] RESET_V = {2'b11, 13'b0};

    function automatic int ticks(input int p);
        return (p == 0) ? 5 : (p == 1) ? 2 : 3;
    endfunction

    function automatic logic [2:0] lamp_of(input int p);
        return (p == 0) ? 3'b100 : (p == 1) ? 3'b010 : (p == 2) ? 3'b001 : 3'b000;
    endfunction

    task automatic model_edge(input logic [2:0] l, input logic rstn);
        int ph;
        bit good_order, good_len;
        ph = ($countones(l) != 1) ? 3 : l[2] ? 0 : l[1] ? 1 : 2;
        m_eo = 0; m_eord = 0; m_elen = 0;
        if (!rstn) begin
            m_mode = 0; m_ph = 3; m_len = 0; m_cyc = 0; m_any = 0;
        end else begin
            if (ph == 3) begin
                m_eo = 1; m_mode = 0; m_len = 0;
            end else if (ph != m_ph) begin
                if (m_ph != 3) begin
                    good_order = (ph == (m_ph + 1) % 3);
                    good_len   = (m_len == ticks(m_ph));
                    if (m_mode == 0) m_mode = 1;
                    else if (!good_order) begin m_eord = 1; m_mode = 1; end
                    else if (!good_len) begin m_elen = 1; m_mode = 1; end
                    else begin
                        if (m_mode == 2 && m_ph == 2 && m_cyc < 255) m_cyc++;
                        m_mode = 2;
                    end
                end
                m_len = 1;
            end else begin
                if (m_mode == 2 && m_len == ticks(ph)) begin m_elen = 1; m_mode = 0; end
                m_len++;
            end
            m_ph = ph;
            m_any = m_any | m_eo | m_eord | m_elen;
        end
        exp_v = {2'(m_ph), (m_mode == 2), m_eo, m_eord, m_elen, m_any, 8'(m_cyc)};
    endtask

    task automatic step(input logic [2:0] l, input logic rstn);
        {lr, la, lg} = l;
        rst = rstn;
        @(posedge clkin);
        model_edge(l, rstn);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step(3'b000, 1'b0);
            n_tests++;
            if (obs !== RESET_V || exp_v !== RESET_V) begin
                n_fail++;
                $display("FAIL reset: got %h expected %h", obs, RESET_V);
            end
        end
    endtask

    task automatic test_sequence;
        int n = 0;
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 3; p++)
                for (int k = 0; k < ticks(p); k++) begin
                    step(lamp_of(p), 1'b1);
                    n++;
                    n_tests++;
                    if (obs !== exp_v || phase !== 2'(p)) begin
                        n_fail++;
                        $display("FAIL seq cyc%0d: got %h expected %h", n, obs, exp_v);
                    end
                    if (n == 7 || n == 8) begin
                        n_tests++;
                        if (locked !== (n == 8)) begin
                            n_fail++;
                            $display("FAIL seq_lock_edge n%0d: got %b expected %b", n, locked, n == 8);
                        end
                    end
                end
        n_tests++;
        if (cycles !== 8'd2 || err_any !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_end: cycles %0d any %b locked %b expected 2 0 1", cycles, err_any, locked);
        end
    endtask

    task automatic test_amber_long;
        int p_q[$] = '{0, 1, 2, 0};
        int l_q[$] = '{5, 3, 3, 1};
        for (int s = 0; s < p_q.size(); s++)
            for (int k = 0; k < l_q[s]; k++) begin
                step(lamp_of(p_q[s]), 1'b1);
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL amber_long s%0d k%0d: got %h expected %h", s, k, obs, exp_v);
                end
                if (s == 1 && k == 2) begin
                    n_tests++;
                    if ({err_len, locked, err_any} !== 3'b101) begin
                        n_fail++;
                        $display("FAIL amber_long_err: got len/lock/any %b expected 101", {err_len, locked, err_any});
                    end
                end
            end
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL amber_relock: got %b expected 1", locked);
        end
    endtask

    task automatic test_green_short;
        int p_q[$] = '{0, 1, 2, 0, 1};
        int l_q[$] = '{4, 2, 2, 5, 1};
        logic [7:0] c0;
        c0 = cycles;
        for (int s = 0; s < p_q.size(); s++)
            for (int k = 0; k < l_q[s]; k++) begin
                step(lamp_of(p_q[s]), 1'b1);
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL green_short s%0d k%0d: got %h expected %h", s, k, obs, exp_v);
                end
                if (s == 3 && k == 0) begin
                    n_tests++;
                    if ({err_len, err_order, locked} !== 3'b100) begin
                        n_fail++;
                        $display("FAIL green_short_err: got len/order/lock %b expected 100", {err_len, err_order, locked});
                    end
                end
            end
        n_tests++;
        if (locked !== 1'b1 || cycles !== c0) begin
            n_fail++;
            $display("FAIL green_short_end: locked %b cycles %0d expected 1 %0d", locked, cycles, c0);
        end
    endtask

    task automatic test_order;
        int p_q[$] = '{1, 2, 0, 2};
        int l_q[$] = '{1, 3, 5, 1};
        for (int s = 0; s < p_q.size(); s++)
            for (int k = 0; k < l_q[s]; k++) begin
                step(lamp_of(p_q[s]), 1'b1);
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL order s%0d k%0d: got %h expected %h", s, k, obs, exp_v);
                end
            end
        n_tests++;
        if ({err_order, err_len, locked} !== 3'b100) begin
            n_fail++;
            $display("FAIL order_err: got order/len/lock %b expected 100", {err_order, err_len, locked});
        end
    endtask

    task automatic test_onehot;
        int p_q[$] = '{2, 0, 1, 2, 0};
        int l_q[$] = '{2, 5, 2, 3, 1};
        logic [2:0] bad[2] = '{3'b110, 3'b000};
        for (int s = 0; s < p_q.size(); s++)
            for (int k = 0; k < l_q[s]; k++) begin
                step(lamp_of(p_q[s]), 1'b1);
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL onehot_pre s%0d k%0d: got %h expected %h", s, k, obs, exp_v);
                end
            end
        for (int i = 0; i < 2; i++) begin
            step(bad[i], 1'b1);
            n_tests++;
            if (obs !== exp_v || {phase, err_onehot, locked} !== 4'b1110) begin
                n_fail++;
                $display("FAIL onehot %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < ticks(p); k++) step(lamp_of(p), 1'b1);
        step(lamp_of(0), 1'b1);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < ((p == 2) ? 1 : ticks(p)); k++) step(lamp_of(p), 1'b1);
        n_tests++;
        if (locked !== 1'b1 || exp_v[12] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got locked %b expected 1", locked);
        end
        step(lamp_of(2), 1'b0);
        n_tests++;
        if (obs !== RESET_V) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected %h", obs, RESET_V);
        end
    endtask

    task automatic test_saturation;
        logic [7:0] prev = 8'd0;
        for (int c = 0; c < 260; c++)
            for (int p = 0; p < 3; p++)
                for (int k = 0; k < ticks(p); k++) begin
                    step(lamp_of(p), 1'b1);
                    if (cycles < prev) begin
                        n_fail++;
                        $display("FAIL sat_wrap: got %0d after %0d", cycles, prev);
                    end
                    prev = cycles;
                end
        step(lamp_of(0), 1'b1);
        n_tests++;
        if (cycles !== 8'd255 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL saturate: got %0d (%h) expected 255 (%h)", cycles, obs, exp_v);
        end
    endtask

    task automatic test_random;
        int cur, nph, len, r;
        logic [2:0] bad[5] = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};
        cur = $urandom_range(0, 2);
        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                len = $urandom_range(1, 2);
                for (int k = 0; k < len; k++) begin
                    step(bad[$urandom_range(0, 4)], 1'b1);
                    n_tests++;
                    if (obs !== exp_v) begin
                        n_fail++;
                        $display("FAIL random_bad s%0d: got %h expected %h", s, obs, exp_v);
                    end
                end
                continue;
            end
            nph = (r == 1) ? (cur + 2) % 3 : (cur + 1) % 3;
            len = ticks(nph) + $urandom_range(0, 2) - 1;
            if (r >= 15) len = ticks(nph);
            if (len < 1) len = 1;
            for (int k = 0; k < len; k++) begin
                step(lamp_of(nph), (r == 2 && k == 0) ? 1'b0 : 1'b1);
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL random s%0d k%0d: got %h expected %h", s, k, obs, exp_v);
                end
            end
            cur = nph;
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_amber_long();
        test_green_short();
        test_order();
        test_onehot();
        test_reset_mid();
        test_saturation();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
